program_sequencer: RTL
======================

PROGRAM_SEQUENCER -- requirements
Module: program_sequencer

Interface
REQ-001 The block SHALL have parameter START_ADDR, default 10'd0, the program entry address loaded on start.
REQ-002 The block SHALL have parameter MAX_INSTR, default 16'd1000, the watchdog limit on issued-plus-internal instructions per run.
REQ-003 The block SHALL have port clk  input  1  single system clock; all state updates on rising edge.
REQ-004 The block SHALL have port reset  input  1  reset; synchronous, active-high.
REQ-005 The block SHALL have port start  input  1  one-cycle run request; honoured only in IDLE, HALTED, ERROR.
REQ-006 The block SHALL have port read_data  input  10  instruction word from the instruction ROM, combinational on address.
REQ-007 The block SHALL have port exec_ready  input  1  datapath has completed the issued instruction.
REQ-008 The block SHALL have port branch_eq  input  1  datapath compare result for the issued beq; valid only while exec_ready=1.
REQ-009 The block SHALL have port address  output  10  ROM address; equals the program counter (pc).
REQ-010 The block SHALL have port instr  output  10  latched instruction word.
REQ-011 The block SHALL have port instr_valid  output  1  instr is issued to the datapath.
REQ-012 The block SHALL have port busy  output  1  high in FETCH and ISSUE.
REQ-013 The block SHALL have port done  output  1  high in HALTED.
REQ-014 The block SHALL have port error  output  1  high in ERROR (watchdog expiry).
REQ-015 The block SHALL have port instr_count  output  16  instructions retired in the current run.

Function
REQ-016 The block SHALL implement states IDLE, FETCH, ISSUE, HALTED, ERROR.
REQ-017 In IDLE, HALTED, ERROR, a start pulse SHALL set pc=START_ADDR, clear instr_count to 0 and enter FETCH next cycle.
REQ-018 In FETCH (exactly one cycle), the block SHALL latch instr<=read_data and enter ISSUE.
REQ-019 Decode: halt = instr==10'b0010000010; jump = instr[9:6]==4'b1000 with target {4'b0,instr[5:0]}; beq = instr[9:7]==3'b101 with offset sign-extended instr[2:0]; all other words are datapath ops.
REQ-020 In ISSUE with halt, the block SHALL keep instr_valid=0, increment instr_count and enter HALTED next cycle; pc unchanged.
REQ-021 In ISSUE with jump, the block SHALL keep instr_valid=0, set pc=target, increment instr_count and enter FETCH next cycle.
REQ-022 In ISSUE with beq or datapath op, the block SHALL assert instr_valid and hold instr, pc, state until exec_ready=1.
REQ-023 On the exec_ready=1 cycle, the block SHALL set pc=pc+sext(offset) for beq with branch_eq=1, otherwise pc=pc+1, increment instr_count and enter FETCH; instr_valid drops next cycle.
REQ-024 pc arithmetic SHALL be modulo 1024: 1023+1 -> 0; backward beq offsets wrap below 0.
REQ-025 exec_ready and branch_eq SHALL be ignored outside ISSUE-with-instr_valid; branch_eq SHALL be ignored for non-beq ops.
REQ-026 start SHALL be ignored while busy=1.
REQ-027 When an increment would make instr_count equal MAX_INSTR and the instruction is not halt, the block SHALL enter ERROR instead of FETCH/HALTED; halt on that same retirement SHALL enter HALTED.
REQ-028 instr_count SHALL saturate at 16'hFFFF and SHALL hold its final value in HALTED and ERROR until the next start.
REQ-029 Minimum latency per datapath instruction SHALL be 2 cycles (FETCH + ISSUE with immediate exec_ready); jump and halt SHALL take 2 cycles each.

Reset
REQ-030 On reset=1 at a clock edge, the block SHALL enter IDLE with pc=START_ADDR, instr=10'd0, instr_count=0, instr_valid=0, busy=0, done=0, error=0, regardless of current state, including mid-ISSUE.
REQ-031 Reset SHALL take priority over start and exec_ready in the same cycle.

Verification
REQ-032 The bench SHALL drive ROM {0:sub, 1:jump 3, 2:add, 3:halt} with exec_ready tied high and start pulsed; the required response is addresses 0,1,3, one instr_valid pulse, done=1 and instr_count=3.
REQ-033 The bench SHALL place beq offset 2 at address 4 and run it once with branch_eq=1 and once with branch_eq=0; the required next address is 6 for branch_eq=1 and 5 for branch_eq=0.
REQ-034 The bench SHALL place beq offset -4 (3'b100) at address 1; with branch_eq=1 the next address SHALL be 1021.
REQ-035 The bench SHALL hold exec_ready low for 5 cycles during an add; instr_valid, instr and address SHALL stay stable for those 5 cycles, and start pulses in that window SHALL have no effect.
REQ-036 The bench SHALL run a jump-to-self program with MAX_INSTR=8; after 8 retirements the required response is error=1, busy=0 and instr_count=8.
REQ-037 The bench SHALL assert reset during ISSUE; the next cycle SHALL show IDLE outputs per REQ-030, and a following start SHALL fetch from START_ADDR.

Source files
------------

// File: rtl/program_sequencer.sv
// Instruction sequencer: fetches words from a ROM, runs halt/jump itself,
// hands other words to the datapath, and stops any run that exceeds MAX_INSTR.
module program_sequencer #(
   parameter logic [9:0]  START_ADDR = 10'd0,
   parameter logic [15:0] MAX_INSTR  = 16'd1000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [9:0]  read_data,
   input  logic        exec_ready,
   input  logic        branch_eq,
   output logic [9:0]  address,
   output logic [9:0]  instr,
   output logic        instr_valid,
   output logic        busy,
   output logic        done,
   output logic        error,
   output logic [15:0] instr_count
);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_FETCH  = 3'd1,
      S_ISSUE  = 3'd2,
      S_HALTED = 3'd3,
      S_ERROR  = 3'd4
   } state_t;

   localparam logic [9:0] HALT_WORD = 10'b0010000010;

   state_t      state;
   state_t      state_nx;
   logic [9:0]  pc;
   logic [9:0]  pc_nx;
   logic [9:0]  instr_nx;
   logic        valid_nx;
   logic [15:0] count_nx;
   logic        retire;

   function automatic logic is_halt(input logic [9:0] w);
      return (w == HALT_WORD);
   endfunction

   function automatic logic is_jump(input logic [9:0] w);
      return (w[9:6] == 4'b1000);
   endfunction

   function automatic logic is_beq(input logic [9:0] w);
      return (w[9:7] == 3'b101);
   endfunction

   // Everything that is neither halt nor jump goes out to the datapath, beq included.
   function automatic logic is_exec(input logic [9:0] w);
      return !(is_halt(w) || is_jump(w));
   endfunction

   function automatic logic [9:0] jump_target(input logic [9:0] w);
      return {4'b0000, w[5:0]};
   endfunction

   function automatic logic [9:0] beq_offset(input logic [9:0] w);
      return {{7{w[2]}}, w[2:0]};
   endfunction

   function automatic logic [15:0] sat_inc(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : (v + 16'd1);
   endfunction

   assign address = pc;

   // Next-state, program counter and retirement decisions.
   always_comb begin
      state_nx = state;
      pc_nx    = pc;
      instr_nx = instr;
      valid_nx = instr_valid;
      count_nx = instr_count;
      retire   = 1'b0;
      case (state)
         S_IDLE, S_HALTED, S_ERROR: begin
            if (start) begin
               state_nx = S_FETCH;
               pc_nx    = START_ADDR;
               count_nx = 16'd0;
            end else begin
               state_nx = state;
            end
         end
         S_FETCH: begin
            instr_nx = read_data;
            valid_nx = is_exec(read_data);
            state_nx = S_ISSUE;
         end
         S_ISSUE: begin
            if (is_halt(instr)) begin
               retire   = 1'b1;
               state_nx = S_HALTED;
            end else if (is_jump(instr)) begin
               retire   = 1'b1;
               pc_nx    = jump_target(instr);
               state_nx = S_FETCH;
            end else if (instr_valid && exec_ready) begin
               retire   = 1'b1;
               valid_nx = 1'b0;
               state_nx = S_FETCH;
               if (is_beq(instr) && branch_eq) begin
                  pc_nx = pc + beq_offset(instr);
               end else begin
                  pc_nx = pc + 10'd1;
               end
            end else begin
               state_nx = S_ISSUE;
            end
            // Watchdog: a halt landing exactly on the limit still counts as a clean finish.
            if (retire) begin
               count_nx = sat_inc(instr_count);
               if (!is_halt(instr) && (count_nx == MAX_INSTR)) begin
                  state_nx = S_ERROR;
               end else begin
                  state_nx = state_nx;
               end
            end else begin
               count_nx = instr_count;
            end
         end
         default: begin
            state_nx = S_IDLE;
         end
      endcase
   end

   // State and datapath-facing registers; status flags follow the next state.
   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= S_IDLE;
         pc          <= START_ADDR;
         instr       <= 10'd0;
         instr_valid <= 1'b0;
         instr_count <= 16'd0;
         busy        <= 1'b0;
         done        <= 1'b0;
         error       <= 1'b0;
      end else begin
         state       <= state_nx;
         pc          <= pc_nx;
         instr       <= instr_nx;
         instr_valid <= valid_nx;
         instr_count <= count_nx;
         busy        <= (state_nx == S_FETCH) || (state_nx == S_ISSUE);
         done        <= (state_nx == S_HALTED);
         error       <= (state_nx == S_ERROR);
      end
   end

endmodule
